// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF  = 16;
   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned LATENCY_DEF = 4;

   // Latency counter width; covers the legal LATENCY range 1..15.
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-requester round-robin pick: combinational grant plus last-grant memory.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic d_req,
   input  logic take,
   output logic grant_valid_c,
   output logic grant_port_c,
   output logic last_grant
);

   // Single requester wins outright; under contention the port not granted last wins.
   always_comb begin
      grant_valid_c = i_req | d_req;
      grant_port_c  = PORT_I;
      if (i_req && d_req) begin
         grant_port_c = ~last_grant;
      end else if (d_req) begin
         grant_port_c = PORT_D;
      end
   end

   // Remember the winner of each accepted grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= PORT_I;
      end else if (take) begin
         last_grant <= grant_port_c;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data ports.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned LATENCY = LATENCY_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   // Reject latencies the counter cannot represent.
   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_arbiter: LATENCY must be within 1..15");
   end

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              take;
   logic              port_q;
   logic              port_d;
   logic              wr_q;
   logic              wr_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              grant_valid_c;
   logic              grant_port_c;
   logic              last_grant;
   logic              last_cycle_c;

   arb_rr2 u_arb (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req         (i_req),
      .d_req         (d_req),
      .take          (take),
      .grant_valid_c (grant_valid_c),
      .grant_port_c  (grant_port_c),
      .last_grant    (last_grant)
   );

   assign last_cycle_c = (state_q == ACCESS) && (cnt_q == '0);

   // FSM and latency counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter and the request fields latched at grant.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      take    = 1'b0;
      port_d  = port_q;
      wr_d    = wr_q;
      addr_d  = mem_addr;
      wdata_d = mem_data_in;
      case (state_q)
         IDLE: begin
            if (grant_valid_c) begin
               take    = 1'b1;
               state_d = ACCESS;
               cnt_d   = CNT_LOAD;
               port_d  = grant_port_c;
               if (grant_port_c == PORT_D) begin
                  wr_d    = d_wr;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end else begin
                  wr_d    = 1'b0;
                  addr_d  = i_addr;
                  wdata_d = '0;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered memory controls, acks and busy, all derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         port_q      <= PORT_I;
         wr_q        <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         mem_enable  <= 1'b0;
         mem_wr      <= 1'b0;
         i_ack       <= 1'b0;
         d_ack       <= 1'b0;
         busy        <= 1'b0;
      end else begin
         port_q      <= port_d;
         wr_q        <= wr_d;
         mem_addr    <= addr_d;
         mem_data_in <= wdata_d;
         mem_enable  <= (state_d == ACCESS);
         mem_wr      <= (state_d == ACCESS) && wr_d;
         i_ack       <= (state_d == RESP) && (port_d == PORT_I);
         d_ack       <= (state_d == RESP) && (port_d == PORT_D);
         busy        <= (state_d != IDLE);
      end
   end

   // Read data captured in the last access cycle; held until that port's next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rdata <= '0;
         d_rdata <= '0;
      end else if (last_cycle_c && !wr_q) begin
         if (port_q == PORT_I) begin
            i_rdata <= mem_data_out;
         end else begin
            d_rdata <= mem_data_out;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=4 instance (a) and LATENCY=1 instance (b).
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   typedef struct {
      logic        port;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   // instance a (LATENCY 4)
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_ack, d_ack, mem_enable, mem_wr, busy;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;
   // instance b (LATENCY 1)
   logic        i_req_b, d_req_b, d_wr_b;
   logic [15:0] i_addr_b, d_addr_b, d_wdata_b;
   logic        i_ack_b, d_ack_b, mem_enable_b, mem_wr_b, busy_b;
   logic [15:0] i_rdata_b, d_rdata_b, mem_addr_b, mem_data_in_b, mem_data_out_b;

   logic [15:0] mem_a [0:65535];
   logic [15:0] mem_b [0:65535];
   exp_t        q_a[$];
   exp_t        q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_data_out   = mem_a[mem_addr];
   assign mem_data_out_b = mem_b[mem_addr_b];

   mem_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
   );

   mem_arbiter #(.LATENCY(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req_b), .i_addr(i_addr_b), .i_ack(i_ack_b), .i_rdata(i_rdata_b),
      .d_req(d_req_b), .d_wr(d_wr_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
      .d_ack(d_ack_b), .d_rdata(d_rdata_b),
      .mem_enable(mem_enable_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
      .mem_data_in(mem_data_in_b), .mem_data_out(mem_data_out_b), .busy(busy_b)
   );

   task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   function automatic void push_a(input logic port, input logic [15:0] data, input int c);
      exp_t e;
      e.port = port;
      e.data = data;
      e.cyc  = c;
      q_a.push_back(e);
   endfunction

   function automatic void push_b(input logic port, input logic [15:0] data, input int c);
      exp_t e;
      e.port = port;
      e.data = data;
      e.cyc  = c;
      q_b.push_back(e);
   endfunction

   // Step instance a until ni fetch acks and nd data acks are seen, dropping each
   // request on its final ack, then step into the following IDLE cycle.
   task automatic wait_acks(input int ni, input int nd, output int en_n, output int wr_n);
      int ic = 0;
      int dc = 0;
      int k  = 0;
      en_n = 0;
      wr_n = 0;
      while ((ic < ni || dc < nd) && k < 60) begin
         @(posedge clk); #1;
         k++;
         if (mem_enable) en_n++;
         if (mem_wr) wr_n++;
         if (i_ack) begin
            ic++;
            if (ic >= ni) i_req = 1'b0;
         end
         if (d_ack) begin
            dc++;
            if (dc >= nd) d_req = 1'b0;
         end
      end
      if (ic < ni || dc < nd) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_timeout_a: got i=%0d d=%0d acks, required i=%0d d=%0d", ic, dc, ni, nd);
         i_req = 1'b0;
         d_req = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   // One transaction on instance b; the ack is required two cycles after the request.
   task automatic run_b(input logic port, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp);
      int  t = cyc;
      int  k = 0;
      bit  got = 1'b0;
      push_b(port, exp, t + 2);
      if (port == PORT_D) begin
         d_wr_b = wr; d_addr_b = addr; d_wdata_b = wdata; d_req_b = 1'b1;
      end else begin
         i_addr_b = addr; i_req_b = 1'b1;
      end
      while (!got && k < 20) begin
         @(posedge clk); #1;
         k++;
         got = (port == PORT_D) ? d_ack_b : i_ack_b;
      end
      i_req_b = 1'b0;
      d_req_b = 1'b0;
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_timeout_b: got no ack in %0d cycles, required ack at cycle %0d", k, t + 2);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int          t;
      int          en;
      int          wr;
      int          n;
      exp_t        m_a;
      exp_t        m_b;
      logic [15:0] got_a;
      logic [15:0] got_b;

      for (int k = 0; k < 65536; k++) begin
         mem_a[k] = '0;
         mem_b[k] = '0;
      end
      mem_a[16'h0000] = 16'hB123;
      mem_a[16'h0002] = 16'hA002;
      mem_a[16'h0003] = 16'hA003;
      mem_a[16'h0004] = 16'hA004;
      mem_a[16'h0010] = 16'hD010;
      mem_a[16'h0011] = 16'hD011;
      mem_b[16'h0000] = 16'hB123;

      rst_n = 1'b0;
      i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
      i_req_b = 1'b0; d_req_b = 1'b0; d_wr_b = 1'b0; i_addr_b = '0; d_addr_b = '0; d_wdata_b = '0;

      fork
         // memory write ports
         forever begin
            @(posedge clk);
            if (mem_enable && mem_wr) mem_a[mem_addr] = mem_data_in;
            if (mem_enable_b && mem_wr_b) mem_b[mem_addr_b] = mem_data_in_b;
         end
         // monitor a: every ack against the scoreboard
         forever begin
            @(negedge clk);
            if (rst_n && (i_ack || d_ack)) begin
               vectors++;
               got_a = d_ack ? d_rdata : i_rdata;
               if (q_a.size() == 0) begin
                  miscompares++;
                  $display("FAIL ack_unexpected_a: got i_ack=%0b d_ack=%0b at cycle %0d, required no ack",
                           i_ack, d_ack, cyc);
               end else begin
                  m_a = q_a.pop_front();
                  if ((i_ack && d_ack) || d_ack != m_a.port || got_a !== m_a.data || cyc != m_a.cyc) begin
                     miscompares++;
                     $display("FAIL ack_a: got i_ack=%0b d_ack=%0b data=%h cycle=%0d, required port=%0b data=%h cycle=%0d",
                              i_ack, d_ack, got_a, cyc, m_a.port, m_a.data, m_a.cyc);
                  end
               end
            end
         end
         // monitor b
         forever begin
            @(negedge clk);
            if (rst_n && (i_ack_b || d_ack_b)) begin
               vectors++;
               got_b = d_ack_b ? d_rdata_b : i_rdata_b;
               if (q_b.size() == 0) begin
                  miscompares++;
                  $display("FAIL ack_unexpected_b: got i_ack=%0b d_ack=%0b at cycle %0d, required no ack",
                           i_ack_b, d_ack_b, cyc);
               end else begin
                  m_b = q_b.pop_front();
                  if ((i_ack_b && d_ack_b) || d_ack_b != m_b.port || got_b !== m_b.data || cyc != m_b.cyc) begin
                     miscompares++;
                     $display("FAIL ack_b: got i_ack=%0b d_ack=%0b data=%h cycle=%0d, required port=%0b data=%h cycle=%0d",
                              i_ack_b, d_ack_b, got_b, cyc, m_b.port, m_b.data, m_b.cyc);
                  end
               end
            end
         end
      join_none

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs_a", 80'({i_ack, d_ack, i_rdata, d_rdata, mem_enable, mem_wr,
                                 mem_addr, mem_data_in, busy}), '0);
      check("reset_outs_b", 80'({i_ack_b, d_ack_b, i_rdata_b, d_rdata_b, mem_enable_b, mem_wr_b,
                                 mem_addr_b, mem_data_in_b, busy_b}), '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single fetch of word 0
      t = cyc;
      i_addr = 16'h0000; i_req = 1'b1;
      push_a(PORT_I, 16'hB123, t + 5);
      wait_acks(1, 0, en, wr);
      check("fetch_enable_cycles", 80'(en), 80'(4));
      check("fetch_wr_cycles", 80'(wr), 80'(0));

      // contention held for four transactions: D, I, D, I six cycles apart
      t = cyc;
      i_addr = 16'h0002; d_addr = 16'h0010; d_wr = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      push_a(PORT_D, 16'hD010, t + 5);
      push_a(PORT_I, 16'hA002, t + 11);
      push_a(PORT_D, 16'hD010, t + 17);
      push_a(PORT_I, 16'hA002, t + 23);
      wait_acks(2, 2, en, wr);
      check("contend_enable_cycles", 80'(en), 80'(16));

      // store then load of 0x0040; the store ack keeps the previous load data
      t = cyc;
      d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF; d_req = 1'b1;
      push_a(PORT_D, 16'hD010, t + 5);
      wait_acks(0, 1, en, wr);
      check("store_wr_cycles", 80'(wr), 80'(4));
      check("store_mem_word", 80'(mem_a[16'h0040]), 80'(16'hBEEF));
      t = cyc;
      d_wr = 1'b0; d_req = 1'b1;
      push_a(PORT_D, 16'hBEEF, t + 5);
      wait_acks(0, 1, en, wr);
      check("load_wr_cycles", 80'(wr), 80'(0));

      // data request arriving during a fetch access waits for the next IDLE
      t = cyc;
      i_addr = 16'h0003; i_req = 1'b1;
      push_a(PORT_I, 16'hA003, t + 5);
      @(posedge clk); #1;
      @(posedge clk); #1;
      d_addr = 16'h0011; d_wr = 1'b0; d_req = 1'b1;
      push_a(PORT_D, 16'hD011, t + 11);
      @(posedge clk); #1;
      check("mid_fetch_addr", 80'(mem_addr), 80'(16'h0003));
      check("mid_fetch_busy_wr", 80'({busy, mem_wr, mem_enable}), 80'(3'b101));
      wait_acks(1, 1, en, wr);

      // reset in the third access cycle of a fetch drops it without an ack
      t = cyc;
      i_addr = 16'h0004; i_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      i_req = 1'b0;
      #1;
      check("async_reset_outs", 80'({i_ack, d_ack, i_rdata, d_rdata, mem_enable, mem_wr,
                                     mem_addr, mem_data_in, busy}), '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (i_ack || d_ack || busy) n++;
      end
      check("idle_after_reset", 80'(n), 80'(0));
      t = cyc;
      i_req = 1'b1;
      push_a(PORT_I, 16'hA004, t + 5);
      wait_acks(1, 0, en, wr);
      check("refetch_enable_cycles", 80'(en), 80'(4));

      // LATENCY=1 instance
      run_b(PORT_D, 1'b1, 16'h0020, 16'h5555, 16'h0000);
      run_b(PORT_D, 1'b0, 16'h0020, 16'h0000, 16'h5555);
      run_b(PORT_D, 1'b1, 16'h0021, 16'h7777, 16'h5555);
      check("lat1_store_word", 80'(mem_b[16'h0021]), 80'(16'h7777));
      run_b(PORT_I, 1'b0, 16'h0000, 16'h0000, 16'hB123);

      repeat (4) @(posedge clk);
      #1;
      check("pending_acks_a", 80'(q_a.size()), 80'(0));
      check("pending_acks_b", 80'(q_b.size()), 80'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
